serial_pixel_core: RTL and testbench
====================================

Name: serial_pixel_core

Overview:
- Combines a UART 8N1 byte receiver and a WS2812-style single-wire pixel serialiser in one clocked block.
- The receiver turns the asynchronous serial input into byte/strobe pairs.
- The serialiser accepts one 24-bit colour (red, green, blue) per handshake and drives the pixel data line.
- It sits between the board-level serial pin and the LED strip pin. Upstream control logic stores the colours and sequences the pixels.

Parameters:
- CLKS_PER_BIT, 104, system clocks per UART bit (12 MHz / 115200).
- BIT_CLKS, 15, system clocks per pixel data bit (1.25 us at 12 MHz).
- T0H_CLKS, 4, high time of a pixel '0' bit, in clocks.
- T1H_CLKS, 8, high time of a pixel '1' bit, in clocks.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- RX  in  1  asynchronous UART input; idles high.
- rx_byte  out  8  last correctly received byte.
- rx_valid  out  1  one-cycle strobe; rx_byte is new in this cycle.
- pix_valid  in  1  request to send red/green/blue.
- red  in  8  red intensity.
- green  in  8  green intensity.
- blue  in  8  blue intensity.
- pix_dout  out  1  serial data line to the LED strip.
- busy  out  1  serialiser is transmitting; requests are ignored.

Behaviour:
- Reset (RST high at a clock edge):
  - rx_byte=0x00, rx_valid=0, pix_dout=0, busy=0.
  - Both state machines go to IDLE; the RX synchroniser is preset to 1.
  - Reset mid-frame or mid-pixel aborts immediately; no partial strobe.
- RX synchroniser: RX passes through 2 flip-flops before use. All RX decisions use the synchronised signal.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronised low moves to START and clears the bit timer.
  - START: after CLKS_PER_BIT/2 clocks, sample the line.
    - Low: go to DATA and clear the timer.
    - High: treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT clocks, sample one bit, LSB first, into a shift register. After the 8th bit go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample the line.
    - High: rx_byte <= shifted byte, rx_valid=1 for exactly the next cycle, then IDLE.
    - Low (framing error): no strobe, rx_byte unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is high, then go to IDLE.
- rx_valid is never high for two consecutive cycles. rx_byte holds its value between strobes.
- Back-to-back frames with no idle gap are received correctly: after the stop sample, a new falling edge is detected.
- Serialiser handshake:
  - Accept in a cycle where pix_valid=1 and busy=0. The shift register loads {green, red, blue}, green MSB first.
  - busy=1 from the next cycle.
  - pix_valid while busy=1 is ignored; it is not queued.
- Per bit (24 bits, MSB first):
  - pix_dout=1 for T1H_CLKS clocks if the bit is 1, else for T0H_CLKS clocks.
  - Then pix_dout=0 for the remainder of BIT_CLKS.
  - Bit periods are contiguous.
- busy stays high for exactly 24*BIT_CLKS cycles (360 at defaults), then returns to 0 with pix_dout=0.
- A new pixel may be accepted in the first cycle busy=0, which gives back-to-back pixels.
- pix_dout is 0 whenever busy=0.
- Latch/reset low time (>50 us) is the caller's responsibility; it is achieved by not requesting.
- Colour inputs are sampled only in the accept cycle. Later changes do not affect the pixel in flight.
- Receiver and serialiser are fully independent; simultaneous activity has no interaction.

Test Plan:
- Reset: hold RST for 2 cycles with RX=1 -> rx_byte=0x00, rx_valid=0, busy=0, pix_dout=0.
- UART 0xA5 at 104 clk/bit (start, 1,0,1,0,0,1,0,1, stop) -> exactly one rx_valid pulse with rx_byte=0xA5, about 9.5 bit times after the falling edge. Then send 0x3C back-to-back -> second pulse with 0x3C.
- Glitch and framing:
  - 20-cycle low pulse on RX -> no rx_valid.
  - Frame 0x55 with stop bit low -> no rx_valid, rx_byte stays 0x3C; next good frame 0x01 is received.
- Pixel red=0x40, green=0x00, blue=0x80, pulse pix_valid 1 cycle ->
  - busy high for 360 cycles.
  - pix_dout high-times: 8x4 (green); then 4,8,4,4,4,4,4,4 (red); then 8,4,4,4,4,4,4,4 (blue); each in a 15-cycle period.
- Hold pix_valid=1 continuously with 0xFF/0xFF/0xFF -> second pixel starts the cycle after busy falls. Changing the inputs mid-pixel has no effect, and no request is accepted while busy.
- Simultaneous: receive 0x7E while sending a pixel -> both results are correct and their timing is unchanged.

Source files
------------

// File: rtl/serial_pixel_core.sv
// UART 8N1 byte receiver plus WS2812-style single-wire pixel serialiser.
// The two halves share only the clock and reset.
module serial_pixel_core #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned BIT_CLKS     = 15,
    parameter int unsigned T0H_CLKS     = 4,
    parameter int unsigned T1H_CLKS     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       pix_valid,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       pix_dout,
    output logic       busy
);

    localparam int unsigned RX_TW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned PX_TW    = $clog2(BIT_CLKS + 1);
    localparam int unsigned PIX_BITS = 24;
    localparam int unsigned PX_BW    = $clog2(PIX_BITS);

    localparam logic [RX_TW-1:0] RX_HALF_LAST = RX_TW'(HALF_BIT - 1);
    localparam logic [RX_TW-1:0] RX_BIT_LAST  = RX_TW'(CLKS_PER_BIT - 1);
    localparam logic [PX_TW-1:0] PX_TICK_LAST = PX_TW'(BIT_CLKS - 1);
    localparam logic [PX_TW-1:0] T0H          = PX_TW'(T0H_CLKS);
    localparam logic [PX_TW-1:0] T1H          = PX_TW'(T1H_CLKS);
    localparam logic [PX_BW-1:0] PX_BIT_LAST  = PX_BW'(PIX_BITS - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic {
        PX_IDLE,
        PX_SEND
    } px_state_t;

    rx_state_t          rx_state;
    logic               rx_meta;
    logic               rx_sync;
    logic [RX_TW-1:0]   rx_timer;
    logic [2:0]         rx_bit;
    logic [7:0]         rx_shift;

    px_state_t          px_state;
    logic [PIX_BITS-1:0] px_shift;
    logic [PX_TW-1:0]   px_tick;
    logic [PX_BW-1:0]   px_bit;
    logic [PX_TW-1:0]   px_high_c;

    // Receiver: two-flop synchroniser, then mid-bit sampling, LSB first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_meta  <= RX;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                        rx_timer <= '0;
                    end
                end
                RX_START: begin
                    if (rx_timer == RX_HALF_LAST) begin
                        rx_timer <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_timer == RX_BIT_LAST) begin
                        rx_timer <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_timer == RX_BIT_LAST) begin
                        rx_timer <= '0;
                        if (rx_sync) begin
                            rx_byte  <= rx_shift;
                            rx_valid <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_timer <= rx_timer + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // High time of the bit currently at the head of the shift register.
    assign px_high_c = px_shift[PIX_BITS-1] ? T1H : T0H;

    // Serialiser: each bit starts high and drops after its high time.
    always_ff @(posedge CLK) begin
        if (RST) begin
            px_state <= PX_IDLE;
            px_shift <= '0;
            px_tick  <= '0;
            px_bit   <= '0;
            busy     <= 1'b0;
            pix_dout <= 1'b0;
        end else begin
            case (px_state)
                PX_IDLE: begin
                    busy     <= 1'b0;
                    pix_dout <= 1'b0;
                    if (pix_valid) begin
                        px_shift <= {green, red, blue};
                        px_tick  <= '0;
                        px_bit   <= '0;
                        busy     <= 1'b1;
                        pix_dout <= 1'b1;
                        px_state <= PX_SEND;
                    end
                end
                PX_SEND: begin
                    if (px_tick == PX_TICK_LAST) begin
                        px_tick <= '0;
                        if (px_bit == PX_BIT_LAST) begin
                            busy     <= 1'b0;
                            pix_dout <= 1'b0;
                            px_state <= PX_IDLE;
                        end else begin
                            px_bit   <= px_bit + 1'b1;
                            px_shift <= {px_shift[PIX_BITS-2:0], 1'b0};
                            pix_dout <= 1'b1;
                        end
                    end else begin
                        px_tick  <= px_tick + 1'b1;
                        pix_dout <= (PX_TW'(px_tick + 1'b1) < px_high_c);
                    end
                end
                default: px_state <= PX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pixel_core.sv
// Scoreboard bench for serial_pixel_core: stimulus pushes expected bytes and
// pixels with their hand-computed start cycles; monitors pop and compare.
module tb_serial_pixel_core;

    localparam int RX_LAT   = 991;   // falling edge to strobe, in clocks
    localparam int BIT_C    = 15;
    localparam int PX_LEN   = 360;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       pix_valid;
    logic [7:0] red, green, blue;
    logic       pix_dout;
    logic       busy;

    serial_pixel_core dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX       (RX),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .pix_valid(pix_valid),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .pix_dout (pix_dout),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  b;
        int unsigned t;
    } rx_exp_t;

    typedef struct {
        logic [23:0] grb;
        int unsigned t;
    } px_exp_t;

    rx_exp_t rx_q[$];
    px_exp_t px_q[$];

    task automatic check(input string name, input bit ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Receiver monitor
    logic prev_rx_valid = 1'b0;
    always @(negedge CLK) begin
        if (!RST && rx_valid) begin
            rx_exp_t e;
            check("rx_single_cycle", !prev_rx_valid, 32'(prev_rx_valid), 32'd0);
            if (rx_q.size() == 0) begin
                check("rx_unexpected_strobe", 1'b0, 32'(rx_byte), 32'd0);
            end else begin
                e = rx_q.pop_front();
                check("rx_byte", rx_byte == e.b, 32'(rx_byte), 32'(e.b));
                check("rx_time", (cyc + 2 >= e.t) && (cyc <= e.t + 2), cyc, e.t);
            end
        end
        prev_rx_valid = RST ? 1'b0 : rx_valid;
    end

    // Pixel monitor: capture pix_dout over each busy window
    logic        prev_busy = 1'b0;
    logic        wave [0:511];
    int unsigned widx   = 0;
    int unsigned wstart = 0;

    task automatic finish_pixel();
        px_exp_t     e;
        logic [14:0] m, x;
        int          hi;
        if (px_q.size() == 0) begin
            check("px_unexpected", 1'b0, wstart, 32'd0);
            return;
        end
        e = px_q.pop_front();
        check("px_start", wstart == e.t, wstart, e.t);
        check("px_busy_len", widx == PX_LEN, widx, 32'(PX_LEN));
        for (int i = 0; i < 24; i++) begin
            hi = e.grb[23-i] ? 8 : 4;
            for (int j = 0; j < BIT_C; j++) begin
                m[14-j] = wave[i*BIT_C+j];
                x[14-j] = (j < hi);
            end
            check($sformatf("px_bit%0d", i), m == x, 32'(m), 32'(x));
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (busy) begin
                if (!prev_busy) begin
                    widx   = 0;
                    wstart = cyc;
                end
                if (widx < 512) wave[widx] = pix_dout;
                widx++;
            end else begin
                check("idle_dout_low", pix_dout == 1'b0, 32'(pix_dout), 32'd0);
                if (prev_busy) finish_pixel();
            end
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    task automatic uart_send(input logic [7:0] b, input bit good_stop);
        @(posedge CLK); #1;
        RX = 1'b0;
        if (good_stop) rx_q.push_back('{b, cyc + RX_LAT});
        for (int i = 0; i < 8; i++) begin
            repeat (104) @(posedge CLK);
            #1 RX = b[i];
        end
        repeat (104) @(posedge CLK);
        #1 RX = good_stop;
        repeat (104) @(posedge CLK);
        #1 RX = 1'b1;
    endtask

    task automatic pix_send(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
        @(posedge CLK); #1;
        green = g; red = r; blue = b; pix_valid = 1'b1;
        px_q.push_back('{{g, r, b}, cyc + 1});
        @(posedge CLK); #1;
        pix_valid = 1'b0;
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
    endtask

    task automatic wait_pix_idle();
        int n = 0;
        @(posedge CLK);
        while (busy && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        check("px_idle_timeout", !busy, 32'(busy), 32'd0);
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        int          n;
        RST = 1'b1; RX = 1'b1; pix_valid = 1'b0;
        red = 8'h00; green = 8'h00; blue = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rx_byte",  rx_byte == 8'h00, 32'(rx_byte), 32'h0);
        check("rst_rx_valid", rx_valid == 1'b0, 32'(rx_valid), 32'h0);
        check("rst_busy",     busy == 1'b0, 32'(busy), 32'h0);
        check("rst_pix_dout", pix_dout == 1'b0, 32'(pix_dout), 32'h0);
        RST = 1'b0;

        // Two back-to-back frames
        uart_send(8'hA5, 1'b1);
        uart_send(8'h3C, 1'b1);
        repeat (200) @(posedge CLK);

        // Short glitch must not start a frame
        @(posedge CLK); #1 RX = 1'b0;
        repeat (20) @(posedge CLK);
        #1 RX = 1'b1;
        repeat (300) @(posedge CLK);

        // Framing error keeps old byte, then a good frame
        uart_send(8'h55, 1'b0);
        repeat (50) @(posedge CLK);
        #1 check("rx_byte_hold", rx_byte == 8'h3C, 32'(rx_byte), 32'h3C);
        uart_send(8'h01, 1'b1);
        repeat (200) @(posedge CLK);

        // Single pixel: green 0x00, red 0x40, blue 0x80
        pix_send(8'h00, 8'h40, 8'h80);
        wait_pix_idle();

        // Held request: second pixel starts one cycle after busy falls
        @(posedge CLK); #1;
        k = cyc;
        red = 8'hFF; green = 8'hFF; blue = 8'hFF; pix_valid = 1'b1;
        px_q.push_back('{24'hFFFFFF, k + 1});
        px_q.push_back('{{8'h34, 8'h12, 8'h56}, k + 362});
        repeat (100) @(posedge CLK);
        #1 red = 8'h12; green = 8'h34; blue = 8'h56;
        repeat (300) @(posedge CLK);
        #1 pix_valid = 1'b0;
        red = 8'hAA; green = 8'hAA; blue = 8'hAA;
        wait_pix_idle();
        wait_pix_idle();
        repeat (20) @(posedge CLK);

        // Receiver and serialiser active together
        fork
            uart_send(8'h7E, 1'b1);
            begin
                repeat (300) @(posedge CLK);
                pix_send(8'hC3, 8'h18, 8'hE7);
            end
        join
        repeat (200) @(posedge CLK);

        n = 0;
        while ((rx_q.size() != 0 || px_q.size() != 0) && n < 5000) begin
            @(posedge CLK);
            n++;
        end
        check("rx_queue_drained", rx_q.size() == 0, 32'(rx_q.size()), 32'd0);
        check("px_queue_drained", px_q.size() == 0, 32'(px_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
